pixel_line_packer: RTL

Downstream consumer of the serial 1-bit pixel stream produced by the frame serializer. It packs consecutive pixels MSB-first into `WORD_W`-bit words, tags each word with its linear word address within the frame, and buffers the words in a small FIFO for a memory/VGA-buffer writer with ready/valid backpressure. The pixel source cannot stall, so the block detects and flags overflow. It reports frame completion once every word has drained.

---
 rtl/pixel_line_packer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pixel_line_packer.sv
// Packs a serial 1-bit pixel stream MSB-first into WORD_W-bit words tagged
// with their linear frame word address, and queues them for a ready/valid consumer.
// Ports: iCLK, iRST_n (async low); iSTART frame pulse; iPIXEL/iVALID pixel in;
//   oWORD/oADDR/oVALID/iREADY word out; oBUSY, oFRAME_DONE, oOVERFLOW status.
module pixel_line_packer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iSTART,
    input  logic              iPIXEL,
    input  logic              iVALID,
    output logic [WORD_W-1:0] oWORD,
    output logic [ADDR_W-1:0] oADDR,
    output logic              oVALID,
    input  logic              iREADY,
    output logic              oBUSY,
    output logic              oFRAME_DONE,
    output logic              oOVERFLOW
);

    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-2:0] shreg_q, shreg_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PW:0]       wr_q, wr_d;
    logic [PW:0]       rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic [WORD_W-1:0] mem_w [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_a [FIFO_DEPTH];

    logic              empty;
    logic              full;
    logic              pop;
    logic              pix;
    logic              wdone;
    logic              last;
    logic              push;
    logic [WORD_W-1:0] word_new;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[PW] != rd_q[PW]) &&
                      (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop      = !empty && iREADY;
    assign pix      = iVALID && !iSTART && (state_q == S_PACK);
    assign wdone    = pix && (bcnt_q == BW'(WORD_W - 1));
    assign last     = pix && (x_q == XW'(H_ACTIVE - 1)) &&
                      (y_q == YW'(V_ACTIVE - 1));
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign push     = wdone && (!full || pop);
    assign word_new = {shreg_q, iPIXEL};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        wr_d    = wr_q + {{PW{1'b0}}, push};
        rd_d    = rd_q + {{PW{1'b0}}, pop};
        if (iSTART) begin
            state_d = S_PACK;
            bcnt_d  = '0;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            ovf_d   = 1'b0;
            // Aborting a frame discards its queued words; words left
            // from a completed frame stay poppable.
            if (state_q != S_IDLE) begin
                wr_d = '0;
                rd_d = '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_PACK: begin
                    if (pix) begin
                        shreg_d = word_new[WORD_W-2:0];
                        if (wdone) begin
                            bcnt_d = '0;
                            addr_d = addr_q + ADDR_W'(1);
                            if (!push) begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                        if (x_q == XW'(H_ACTIVE - 1)) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                        if (last) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (empty) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge iCLK) begin
        if (push) begin
            mem_w[wr_q[PW-1:0]] <= word_new;
            mem_a[wr_q[PW-1:0]] <= addr_q;
        end
    end

    assign oVALID      = !empty;
    assign oWORD       = empty ? '0 : mem_w[rd_q[PW-1:0]];
    assign oADDR       = empty ? '0 : mem_a[rd_q[PW-1:0]];
    assign oBUSY       = busy_q;
    assign oFRAME_DONE = done_q;
    assign oOVERFLOW   = ovf_q;

endmodule
